// File: rtl/dump_pkg.sv
// Shared types and widths for the register-dump scanner.
// Widths match the CPU_FPGA register-view port (4-bit select, 32-bit word).
package dump_pkg;

  localparam int SEL_W  = 4;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    SELECT  = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/sorted_checker.sv
// Sticky signed non-decreasing check over a stream of captured words.
// The first capture after a clear only seeds the previous value.
module sorted_checker
  import dump_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capture,
  input  logic [DATA_W-1:0] data,
  output logic              sorted_ok
);

  logic signed [DATA_W-1:0] data_s;
  logic signed [DATA_W-1:0] prev_p0;
  logic                     first_p0;

  function automatic logic is_descent(input logic signed [DATA_W-1:0] prev,
                                      input logic signed [DATA_W-1:0] cur);
    return cur < prev;
  endfunction

  assign data_s = data;

  always_ff @(posedge clk) begin
    if (rst) begin
      first_p0  <= 1'b1;
      sorted_ok <= 1'b1;
    end else if (clear) begin
      first_p0  <= 1'b1;
      sorted_ok <= 1'b1;
    end else if (capture) begin
      if (!first_p0 && is_descent(prev_p0, data_s)) begin
        sorted_ok <= 1'b0;
      end
      first_p0 <= 1'b0;
    end
  end

  // Previous-value register is pure data; first_p0 guards its use after reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      prev_p0 <= data_s;
    end
  end

endmodule

// File: rtl/reg_dump_scanner.sv
// Waits a fixed run time, then steps output_sel across a register range,
// captures each CPU register value and offers it on a valid/ready stream.
module reg_dump_scanner
  import dump_pkg::*;
#(
  parameter int FIRST_SEL  = 0,
  parameter int LAST_SEL   = 9,
  parameter int RUN_CYCLES = 1150,
  parameter int DWELL      = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] cpu_output,
  output logic [SEL_W-1:0]  output_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              sorted_ok
);

  if (LAST_SEL < FIRST_SEL) begin : g_bad_range
    $error("reg_dump_scanner: LAST_SEL must be >= FIRST_SEL");
  end
  if (FIRST_SEL < 0 || LAST_SEL > 15) begin : g_bad_sel
    $error("reg_dump_scanner: register indices must lie in 0..15");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $error("reg_dump_scanner: DWELL must be at least 1");
  end
  if (RUN_CYCLES < 0 || RUN_CYCLES >= (1 << CNT_W) || DWELL > (1 << CNT_W)) begin : g_bad_cnt
    $error("reg_dump_scanner: RUN_CYCLES/DWELL do not fit the counter width");
  end

  localparam logic [SEL_W-1:0] FIRST_V    = SEL_W'(FIRST_SEL);
  localparam logic [SEL_W-1:0] LAST_V     = SEL_W'(LAST_SEL);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'((RUN_CYCLES == 0) ? 0 : RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [SEL_W-1:0]   sel;
  logic               launch;
  logic               run_end;
  logic               dwell_end;
  logic               capture;
  logic               at_last;

  // A new scan may only be launched from the quiescent states.
  assign launch    = start && ((state == IDLE) || (state == DONE));
  assign run_end   = (cnt == RUN_LAST);
  assign dwell_end = (cnt == DWELL_LAST);
  assign capture   = (state == SELECT) && dwell_end;
  assign at_last   = (sel == LAST_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = (RUN_CYCLES == 0) ? SELECT : WAIT;
        end
      end
      WAIT: begin
        if (run_end) begin
          state_nx = SELECT;
        end
      end
      SELECT: begin
        if (dwell_end) begin
          state_nx = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_nx = at_last ? DONE : SELECT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      DONE:    done = 1'b1;
      PRESENT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // Counter, select index and the captured word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sel       <= FIRST_V;
      out_index <= '0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt <= '0;
            sel <= FIRST_V;
          end
        end
        WAIT: begin
          cnt <= run_end ? '0 : cnt + 1'b1;
        end
        SELECT: begin
          if (dwell_end) begin
            out_data  <= cpu_output;
            out_index <= sel;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            cnt <= '0;
            if (!at_last) begin
              sel <= sel + 1'b1;
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign output_sel = sel;

  sorted_checker u_sorted (
    .clk       (clk),
    .rst       (rst),
    .clear     (launch),
    .capture   (capture),
    .data      (cpu_output),
    .sorted_ok (sorted_ok)
  );

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Scoreboard bench for reg_dump_scanner with a stub CPU register file.
module tb_reg_dump_scanner;

  localparam int FIRST = 0;
  localparam int LAST  = 9;
  localparam int RUN   = 4;
  localparam int DW    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] cpu_output;
  logic [3:0]  output_sel;
  logic        out_valid;
  logic [3:0]  out_index;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic        sorted_ok;

  logic signed [31:0] regs [16];

  typedef struct {
    int          idx;
    logic [31:0] data;
    bit          ok;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  assign cpu_output = regs[output_sel];

  reg_dump_scanner #(
    .FIRST_SEL  (FIRST),
    .LAST_SEL   (LAST),
    .RUN_CYCLES (RUN),
    .DWELL      (DW),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cpu_output (cpu_output),
    .output_sel (output_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .sorted_ok  (sorted_ok)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: the captured prefix FIRST..k is signed non-decreasing.
  function automatic bit prefix_sorted(input int k);
    for (int i = FIRST + 1; i <= k; i++) begin
      if (regs[i] < regs[i-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic load_expect();
    exp_t e;
    for (int i = FIRST; i <= LAST; i++) begin
      e.idx  = i;
      e.data = regs[i];
      e.ok   = prefix_sorted(i);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation on every accepted word, checks holds.
  initial begin : monitor
    logic [31:0] prev_data;
    logic [3:0]  prev_idx;
    bit          prev_stall;
    exp_t        e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_idx   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk("sel_in_range", 64'((output_sel >= FIRST) && (output_sel <= LAST)), 64'd1);
        if (prev_stall) begin
          chk("stall_data_hold", 64'(out_data), 64'(prev_data));
          chk("stall_index_hold", 64'(out_index), 64'(prev_idx));
        end
        if (out_valid) begin
          chk("sel_tracks_index", 64'(output_sel), 64'(out_index));
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_word actual_index=%0d required=none", out_index);
            end else begin
              e = exp_q.pop_front();
              chk("word_index", 64'(out_index), 64'(e.idx));
              chk("word_data", 64'(out_data), 64'(e.data));
              chk("word_sorted_ok", 64'(sorted_ok), 64'(e.ok));
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_idx   = out_index;
      end
    end
  end

  // mode 0: ready held high; 1: random ready; 2: 6-cycle stall at index 3.
  task automatic run_scan(input int mode, input bit restart_mid,
                          output int t_valid, output int t_done);
    int  n;
    int  m;
    bit  stalled;
    stalled   = 1'b0;
    t_valid   = -1;
    t_done    = -1;
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    load_expect();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 3000) begin
      if (mode == 2 && !stalled && out_valid && out_index == 4'd3) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
          tick();
          n++;
          chk("stall_sel_held", 64'(output_sel), 64'd3);
          chk("stall_valid_held", 64'(out_valid), 64'd1);
          chk("stall_index_is_3", 64'(out_index), 64'd3);
        end
        out_ready = 1'b1;
        tick();
        n++;
        m = 1;
        while (!out_valid && m < 50) begin
          tick();
          n++;
          m++;
        end
        chk("resume_latency", 64'(m), 64'(DW + 1));
        chk("resume_index", 64'(out_index), 64'd4);
        continue;
      end
      start = (restart_mid && n == 2);
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (restart_mid && n == 3) chk("busy_in_wait", 64'(busy), 64'd1);
      if (out_valid && t_valid < 0) t_valid = n;
    end
    start = 1'b0;
    if (done) t_done = n;
    chk("scan_done", 64'(done), 64'd1);
    chk("done_not_busy", 64'(busy), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("final_sorted_ok", 64'(sorted_ok), 64'(prefix_sorted(LAST)));
    chk("final_sel_last", 64'(output_sel), 64'(LAST));
    exp_q.delete();
    tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int tv;
    int td;
    int n;
    int v;
    for (int i = 0; i < 16; i++) regs[i] = 100 + i;

    // Reset and idle behaviour
    rst = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      chk("idle_sel", 64'(output_sel), 64'(FIRST));
      chk("idle_valid", 64'(out_valid), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_sorted", 64'(sorted_ok), 64'd1);
    end

    // Ramp registers, ready always high: latency and back-to-back timing
    run_scan(0, 1'b0, tv, td);
    chk("first_valid_latency", 64'(tv), 64'(RUN + DW + 1));
    chk("scan_total_cycles", 64'(td), 64'(RUN + (LAST - FIRST + 1) * (DW + 1) + 1));

    // Sorted bubble-sort result with negatives and a duplicate
    regs[0] = -29; regs[1] = -2; regs[2] = 1;  regs[3] = 3;  regs[4] = 5;
    regs[5] = 5;   regs[6] = 10; regs[7] = 34; regs[8] = 89; regs[9] = 123;
    run_scan(0, 1'b0, tv, td);
    chk("sorted_case_ok", 64'(sorted_ok), 64'd1);

    // Out of order from the second capture onward
    regs[0] = 10; regs[6] = -29;
    run_scan(0, 1'b0, tv, td);
    chk("unsorted_case_ok", 64'(sorted_ok), 64'd0);

    // Backpressure at index 3
    run_scan(2, 1'b0, tv, td);

    // Start again mid-WAIT must not restart the wait
    run_scan(0, 1'b1, tv, td);
    chk("restart_ignored_latency", 64'(tv), 64'(RUN + DW + 1));

    // Reset while presenting index 5
    for (int i = 0; i < 16; i++) regs[i] = 200 - i;
    load_expect();
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_index == 4'd5) && n < 200) begin
      tick();
      n++;
    end
    chk("reached_index5", 64'(out_valid && out_index == 4'd5), 64'd1);
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    exp_q.delete();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sel", 64'(output_sel), 64'(FIRST));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_index", 64'(out_index), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_sorted", 64'(sorted_ok), 64'd1);
    rst = 1'b0;
    tick();
    run_scan(0, 1'b0, tv, td);
    chk("rescan_latency", 64'(tv), 64'(RUN + DW + 1));

    // Randomised register contents and ready pattern
    for (int s = 0; s < 6; s++) begin
      if (s % 2 == 0) begin
        v = -50;
        for (int i = 0; i < 16; i++) begin
          v = v + int'($urandom_range(0, 5));
          regs[i] = v;
        end
      end else begin
        for (int i = 0; i < 16; i++) regs[i] = int'($urandom_range(0, 40)) - 20;
      end
      run_scan(1, 1'b0, tv, td);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
